mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the fetch stage (instruction reads) and the memory stage (data reads/writes). Requesters present level requests; the arbiter latches the winner, drives the memory for a fixed `MEM_LAT` cycles, and returns a registered one-cycle acknowledge with read data. It also produces the stall signals that freeze the F/D buffer and PC (fetch pending) or the whole pipeline (data access pending).

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states,
// last-grant owner and the default address/data width.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  localparam logic LG_FETCH = 1'b0;
  localparam logic LG_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// holds the winner's request on the bus for MEM_LAT cycles and returns a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int MEM_LAT = 2
)
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_if_req,
  input  logic [W-1:0] i_if_addr,
  output logic         o_if_ack,
  output logic [W-1:0] o_if_rdata,
  input  logic         i_d_req,
  input  logic         i_d_we,
  input  logic [W-1:0] i_d_addr,
  input  logic [W-1:0] i_d_wdata,
  output logic         o_d_ack,
  output logic [W-1:0] o_d_rdata,
  output logic         o_mem_en,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  input  logic [W-1:0] i_mem_rdata,
  output logic         o_stall_if,
  output logic         o_stall_pipe
);

  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_addr;
  logic [W-1:0]     r_wdata;
  logic             r_we;
  logic [W-1:0]     r_if_rdata;
  logic [W-1:0]     r_d_rdata;
  logic             r_if_ack;
  logic             r_d_ack;

  logic w_idle;
  logic w_if_elig;
  logic w_d_elig;
  logic w_grant_if;
  logic w_grant_d;

  // A requester being acked this cycle is still holding its request; it must not win again.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_if_elig  = i_if_req & ~r_if_ack;
  assign w_d_elig   = i_d_req  & ~r_d_ack;
  assign w_grant_d  = w_idle & w_d_elig & (~w_if_elig | (r_last_grant == LG_FETCH));
  assign w_grant_if = w_idle & w_if_elig & ~w_grant_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LG_FETCH;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state      <= ST_BUSY_D;
            r_addr       <= i_d_addr;
            r_we         <= i_d_we;
            r_wdata      <= i_d_wdata;
            r_cnt        <= CNT_LOAD;
            r_last_grant <= LG_DATA;
          end else if (w_grant_if) begin
            r_state      <= ST_BUSY_IF;
            r_addr       <= i_if_addr;
            r_we         <= 1'b0;
            r_cnt        <= CNT_LOAD;
            r_last_grant <= LG_FETCH;
          end
        end
        ST_BUSY_IF, ST_BUSY_D: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            if (r_state == ST_BUSY_IF) begin
              r_if_rdata <= i_mem_rdata;
              r_if_ack   <= 1'b1;
            end else begin
              // Writes leave the previously returned read data visible.
              if (!r_we) begin
                r_d_rdata <= i_mem_rdata;
              end
              r_d_ack <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_en     = ~w_idle;
  assign o_mem_we     = (r_state == ST_BUSY_D) & r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;

  assign o_if_ack     = r_if_ack;
  assign o_if_rdata   = r_if_rdata;
  assign o_d_ack      = r_d_ack;
  assign o_d_rdata    = r_d_rdata;

  assign o_stall_if   = i_if_req & ~r_if_ack;
  assign o_stall_pipe = i_d_req  & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter with a queue scoreboard
// and a word-level memory reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W       = 16;
  localparam int MEM_LAT = 2;
  localparam int ACC     = MEM_LAT + 1;
  localparam int N_RAND  = 60;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_ack;
  logic [W-1:0] if_rdata;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic         d_ack;
  logic [W-1:0] d_rdata;
  logic         mem_en;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         stall_if;
  logic         stall_pipe;

  always #5 clk = ~clk;

  mem_port_arbiter #(.W(W), .MEM_LAT(MEM_LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_stall_if(stall_if), .o_stall_pipe(stall_pipe)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic fail_ev(input string nm);
    n_chk++;
    $display("FAIL %s: event occurred, required none", nm);
  endtask

  function automatic logic [W-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'h1234;
    if (a == 8'h50) return 16'h5A5A;
    return {a, ~a} ^ 16'h3C3C;
  endfunction

  // Physical memory: returns data only on the last busy cycle, inverted data otherwise.
  logic [W-1:0] phys [256];
  bit           pv   [256];
  int           bcnt;
  logic [W-1:0] rd_val;

  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else begin
      bcnt <= mem_en ? bcnt + 1 : 0;
      if (mem_en && mem_we) begin
        phys[mem_addr[7:0]] <= mem_wdata;
        pv[mem_addr[7:0]]   <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_val    = pv[mem_addr[7:0]] ? phys[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    mem_rdata = (mem_en && bcnt == MEM_LAT - 1) ? rd_val : ~rd_val;
  end

  // Reference model and scoreboard
  logic [W-1:0] model_mem [256];
  logic [W-1:0] last_d_rd;
  logic [W-1:0] q_if[$];
  logic [W-1:0] q_d[$];

  logic         prev_if_ack = 1'b0;
  logic         prev_d_ack  = 1'b0;
  int           run = 0;
  logic [W-1:0] run_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("stall_if", stall_if, if_req & ~if_ack);
      chk("stall_pipe", stall_pipe, d_req & ~d_ack);
      if (if_ack) begin
        chk("if_ack_one_cycle", prev_if_ack, 1'b0);
        if (q_if.size() == 0) fail_ev("if_ack_unexpected");
        else chk("if_rdata", if_rdata, q_if.pop_front());
      end
      if (d_ack) begin
        chk("d_ack_one_cycle", prev_d_ack, 1'b0);
        if (q_d.size() == 0) fail_ev("d_ack_unexpected");
        else chk("d_rdata", d_rdata, q_d.pop_front());
      end
      if (mem_we && !mem_en) fail_ev("mem_we_without_en");
      if (mem_en) begin
        if (run == 0) run_addr = mem_addr;
        else chk("mem_addr_stable", mem_addr, run_addr);
        run++;
      end else if (run > 0) begin
        chk("busy_len", run, MEM_LAT);
        run = 0;
      end
    end else begin
      run = 0;
    end
    prev_if_ack = if_ack;
    prev_d_ack  = d_ack;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    last_d_rd = '0;
  endtask

  // Returns at the start of the cycle after the ack; lat = ack cycle index, -1 on timeout.
  task automatic wait_ack(input bit is_d, output int lat);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) begin
        lat = k;
        break;
      end
      next_cyc();
    end
    if (lat < 0) fail_ev(is_d ? "d_ack_timeout" : "if_ack_timeout");
    else next_cyc();
  endtask

  task automatic fetch_agent();
    int lat;
    logic [7:0] a;
    for (int n = 0; n < N_RAND; n++) begin
      a = 8'($urandom_range(0, 127));
      if_addr = {8'h00, a};
      q_if.push_back(model_mem[a]);
      if_req = 1'b1;
      wait_ack(1'b0, lat);
      chk("if_latency_bound", (lat >= ACC && lat <= 2 * ACC), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        if_req = 1'b0;
        repeat ($urandom_range(1, 3)) next_cyc();
      end
    end
    if_req = 1'b0;
  endtask

  task automatic data_agent();
    int lat;
    logic [7:0] a;
    logic [W-1:0] wd;
    for (int n = 0; n < N_RAND; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a  = 8'($urandom_range(128, 255));
        wd = W'($urandom);
        d_we = 1'b1; d_addr = {8'h00, a}; d_wdata = wd;
        q_d.push_back(last_d_rd);
        model_mem[a] = wd;
      end else begin
        a = 8'($urandom_range(0, 255));
        d_we = 1'b0; d_addr = {8'h00, a}; d_wdata = W'($urandom);
        q_d.push_back(model_mem[a]);
        last_d_rd = model_mem[a];
      end
      d_req = 1'b1;
      wait_ack(1'b1, lat);
      chk("d_latency_bound", (lat >= ACC && lat <= 2 * ACC), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        d_req = 1'b0;
        repeat ($urandom_range(1, 3)) next_cyc();
      end
    end
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    last_d_rd = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_ack", if_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    next_cyc();
    rst = 1'b0;

    // Fetch only
    if_addr = 16'h0010; if_req = 1'b1;
    q_if.push_back(16'h1234);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("fo_mem_en", mem_en, (c == 1 || c == 2));
      if (c == 1 || c == 2) chk("fo_mem_addr", mem_addr, 16'h0010);
      chk("fo_if_ack", if_ack, (c == 3));
      chk("fo_stall_if", stall_if, (c < 3));
      next_cyc();
      if (c == 3) if_req = 1'b0;
    end

    // Data read to give d_rdata a known non-reset value
    d_addr = 16'h0050; d_we = 1'b0; d_req = 1'b1;
    q_d.push_back(16'h5A5A);
    last_d_rd = 16'h5A5A;
    wait_ack(1'b1, lat);
    chk("d_read_latency", lat, ACC);
    d_req = 1'b0;

    // Data write
    d_addr = 16'h0040; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
    q_d.push_back(last_d_rd);
    model_mem[8'h40] = 16'hBEEF;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("wr_mem_we", mem_we, (c == 1 || c == 2));
      if (c == 1 || c == 2) begin
        chk("wr_mem_addr", mem_addr, 16'h0040);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
      end
      chk("wr_d_ack", d_ack, (c == 3));
      next_cyc();
      if (c == 3) begin d_req = 1'b0; d_we = 1'b0; end
    end

    // Fetch back the written word
    if_addr = 16'h0040; if_req = 1'b1;
    q_if.push_back(model_mem[8'h40]);
    wait_ack(1'b0, lat);
    chk("readback_latency", lat, ACC);
    if_req = 1'b0;

    // Simultaneous requests right after reset: data wins the first tie
    do_reset();
    if_addr = 16'h0020; if_req = 1'b1;
    d_addr = 16'h0030; d_we = 1'b0; d_req = 1'b1;
    q_if.push_back(model_mem[8'h20]);
    q_d.push_back(model_mem[8'h30]);
    last_d_rd = model_mem[8'h30];
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk("sim_d_ack", d_ack, (c == 3));
      chk("sim_if_ack", if_ack, (c == 6));
      chk("sim_mem_en", mem_en, (c == 1 || c == 2 || c == 4 || c == 5));
      if (c == 1) chk("sim_first_grant_addr", mem_addr, 16'h0030);
      if (c == 4) chk("sim_second_grant_addr", mem_addr, 16'h0020);
      next_cyc();
      if (c == 3) d_req = 1'b0;
      if (c == 6) if_req = 1'b0;
    end

    // Reset in cycle 2 of a data read with a fetch pending
    d_addr = 16'h0050; d_we = 1'b0; d_req = 1'b1;
    if_addr = 16'h0024; if_req = 1'b1;
    q_if.push_back(model_mem[8'h24]);
    @(negedge clk);
    chk("ra_c0_mem_en", mem_en, 1'b0);
    next_cyc();
    @(negedge clk);
    chk("ra_c1_mem_en", mem_en, 1'b1);
    chk("ra_c1_mem_addr", mem_addr, 16'h0050);
    next_cyc();
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("ra_mem_en_abort", mem_en, 1'b0);
    chk("ra_no_d_ack", d_ack, 1'b0);
    next_cyc();
    rst = 1'b0; last_d_rd = '0;
    wait_ack(1'b0, lat);
    chk("ra_pending_if_latency", lat, ACC);
    if_req = 1'b0;

    // Fetch request dropped during the access
    if_addr = 16'h0030; if_req = 1'b1;
    q_if.push_back(model_mem[8'h30]);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk("drop_if_ack", if_ack, (c == 3));
      chk("drop_mem_en", mem_en, (c == 1 || c == 2));
      next_cyc();
      if (c == 0) if_req = 1'b0;
    end

    // Alternation with both requests held: D, IF, D, IF every three cycles
    d_addr = 16'h0060; d_we = 1'b0; d_req = 1'b1;
    if_addr = 16'h0070; if_req = 1'b1;
    repeat (2) q_d.push_back(model_mem[8'h60]);
    repeat (2) q_if.push_back(model_mem[8'h70]);
    last_d_rd = model_mem[8'h60];
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      chk("alt_d_ack", d_ack, (c == 3 || c == 9));
      chk("alt_if_ack", if_ack, (c == 6 || c == 12));
      next_cyc();
      if (c == 9)  d_req = 1'b0;
      if (c == 12) if_req = 1'b0;
    end

    // Randomized concurrent traffic
    fork
      fetch_agent();
      data_agent();
    join
    repeat (8) next_cyc();
    chk("q_if_drained", q_if.size(), 0);
    chk("q_d_drained", q_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
